// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // Pipeline control bundle, MSB first in the order listed.
  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic exmem_we;
    logic ifid_flush;
    logic idex_bubble;
    logic memwb_bubble;
  } ctrl_t;

  // NOP control: nothing advances, every stage boundary is loaded with a NOP.
  localparam ctrl_t CTRL_NOP = ctrl_t'(7'b0000_111);
  // Free-running pipeline.
  localparam ctrl_t CTRL_RUN = ctrl_t'(7'b1111_000);
  // Load-use bubble: hold PC and IF/ID, push a bubble into ID/EX, let EX drain.
  localparam ctrl_t CTRL_LU  = ctrl_t'(7'b0011_010);
  // Data memory busy: freeze everything, keep WB fed with NOPs.
  localparam ctrl_t CTRL_MW  = ctrl_t'(7'b0000_001);
  // Redirect: fetch the new target, squash the two wrong-path instructions.
  localparam ctrl_t CTRL_RED = ctrl_t'(7'b1111_110);

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_perf_cnt.sv
// Stall/flush performance counters and data-memory watchdog.
module hazard_perf_cnt #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_inc,
  input  logic             flush_inc,
  input  logic             mem_wait,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_err
);

  localparam int WD_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(MEM_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);
  localparam bit WD_EN = (MEM_TIMEOUT != 0);

  logic [WD_W-1:0] wd_cnt;

  // Wrap-around event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      stall_cycles <= stall_cycles + CNT_W'(stall_inc);
      flush_count  <= flush_count + CNT_W'(flush_inc);
    end
  end

  // Consecutive-wait watchdog; the count saturates so a long hang cannot wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt  <= '0;
      mem_err <= 1'b0;
    end else begin
      if (!mem_wait) begin
        wd_cnt <= '0;
      end else if (wd_cnt != WD_MAX) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (WD_EN && mem_wait && (wd_cnt == WD_LAST)) begin
        mem_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
//   state    | meaning
//   RUN      | pipeline flowing, load-use check active
//   LU_STALL | extra load-use bubble cycles still owed (lu_cnt remaining)
//   MEM_WAIT | data memory busy, whole pipeline frozen, lu_cnt held
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_USE_STALL = 1,
  parameter int MEM_TIMEOUT    = 255,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memtoreg,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             memwb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  // Remaining LU_STALL cycles after the hit cycle itself.
  localparam logic [1:0] LU_LOAD = 2'(LOAD_USE_STALL - 1);

  state_t     state, state_nx;
  logic [1:0] lu_cnt, lu_cnt_nx;
  ctrl_t      ctrl;
  logic       lu_hit, mw, flush_inc;

  assign lu_hit = ex_regwrite & ex_memtoreg & (ex_rd != REG_X0) &
                  ((id_use_rs1 & (ex_rd == id_rs1)) | (id_use_rs2 & (ex_rd == id_rs2)));
  assign mw        = mem_req & ~mem_ready;
  assign flush_inc = ~rst & ~mw & ex_redirect;

  // State and stall-count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      lu_cnt <= '0;
    end else begin
      state  <= state_nx;
      lu_cnt <= lu_cnt_nx;
    end
  end

  // Next-state and control decode; priority is memory wait, redirect, load-use.
  always_comb begin
    ctrl      = CTRL_RUN;
    state_nx  = state;
    lu_cnt_nx = lu_cnt;
    if (rst) begin
      ctrl = CTRL_NOP;
    end else if (mw) begin
      ctrl     = CTRL_MW;
      state_nx = MEM_WAIT;
    end else if (ex_redirect) begin
      ctrl      = CTRL_RED;
      lu_cnt_nx = '0;
      state_nx  = RUN;
    end else if (state == LU_STALL) begin
      ctrl      = CTRL_LU;
      lu_cnt_nx = (lu_cnt == 2'd0) ? 2'd0 : lu_cnt - 2'd1;
      state_nx  = (lu_cnt > 2'd1) ? LU_STALL : RUN;
    end else if (lu_hit) begin
      ctrl      = CTRL_LU;
      lu_cnt_nx = LU_LOAD;
      state_nx  = (LU_LOAD != 2'd0) ? LU_STALL : RUN;
    end else begin
      // RUN, or the cycle MEM_WAIT completes: resume any frozen stall.
      state_nx = (lu_cnt != 2'd0) ? LU_STALL : RUN;
    end
  end

  assign pc_we        = ctrl.pc_we;
  assign ifid_we      = ctrl.ifid_we;
  assign idex_we      = ctrl.idex_we;
  assign exmem_we     = ctrl.exmem_we;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_bubble  = ctrl.idex_bubble;
  assign memwb_bubble = ctrl.memwb_bubble;

  hazard_perf_cnt #(
    .CNT_W       (CNT_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_perf (
    .clk          (clk),
    .rst          (rst),
    .stall_inc    (~ctrl.pc_we),
    .flush_inc    (flush_inc),
    .mem_wait     (mw),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count),
    .mem_err      (mem_err)
  );

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. It sits beside the register file and forwarding logic. It detects load-use hazards against the instruction in ID, freezes the whole pipeline while data memory is busy, and squashes wrong-path instructions on a taken branch/jump resolved in EX. It also keeps stall and flush performance counters and a data-memory watchdog.

Parameters:
LOAD_USE_STALL, 1, bubble cycles inserted per load-use hazard (1..3)
MEM_TIMEOUT, 255, cycles of continuous MEM_WAIT before mem_err; 0 disables the watchdog
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_rs1, id_rs2  in  5  source registers of the instruction in ID
id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
ex_rd  in  5  destination register of the instruction in EX
ex_regwrite, ex_memtoreg  in  1  EX control bits; both 1 means a load
ex_redirect  in  1  taken branch or jump resolved in EX this cycle
mem_req  in  1  MEM-stage instruction accesses data memory
mem_ready  in  1  data memory completes the access this cycle
pc_we, ifid_we, idex_we, exmem_we  out  1  pipeline register write enables
ifid_flush  out  1  load NOP into IF/ID
idex_bubble  out  1  load NOP (all control 0) into ID/EX
memwb_bubble  out  1  load NOP into MEM/WB
mem_err  out  1  sticky watchdog flag
stall_cycles, flush_count  out  CNT_W  performance counters

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- States: RUN, LU_STALL, MEM_WAIT. State, the stall counter, the watchdog counter, the perf counters and mem_err are registered. All enables, flushes and bubbles are combinational from the current state and inputs, so they act in the same cycle.
- While rst=1:
  - pc_we=0, ifid_we=0, idex_we=0, exmem_we=0.
  - ifid_flush=1, idex_bubble=1, memwb_bubble=1.
  - Next state is RUN. Counters and mem_err clear to 0.
  - Reset mid-operation aborts any stall.
- Hazard term: lu_hit = ex_regwrite & ex_memtoreg & (ex_rd!=0) & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)).
- Memory term: mw = mem_req & !mem_ready.
- Priority, evaluated every cycle: mw > ex_redirect > lu_hit / LU_STALL.
- mw=1, any state:
  - All four write enables are 0 and memwb_bubble=1. No flush or bubble is applied to IF/ID or ID/EX.
  - Next state is MEM_WAIT. If coming from LU_STALL, the remaining stall count is held frozen.
- MEM_WAIT with mem_ready=1:
  - The normal action for the cycle is applied.
  - Next state returns to LU_STALL if the stall count is nonzero, otherwise RUN.
- ex_redirect=1 with mw=0:
  - pc_we=1, ifid_flush=1, idex_bubble=1, idex_we=1, exmem_we=1.
  - Any pending load-use stall count is cleared and next state is RUN.
  - flush_count increments by 1.
- lu_hit=1 in RUN with no higher-priority event:
  - pc_we=0, ifid_we=0, idex_bubble=1, exmem_we=1.
  - Stall count loads LOAD_USE_STALL-1. If that is nonzero, next state is LU_STALL.
- LU_STALL:
  - Same outputs as a load-use hit.
  - The count decrements each cycle. State goes to RUN after the cycle in which the count equals 0.
- Default (RUN, no event): all write enables 1, no flushes or bubbles.
- stall_cycles increments on every cycle with pc_we=0 and rst=0.
- Both counters wrap modulo 2^CNT_W.
- Watchdog: counts consecutive MEM_WAIT cycles. At the MEM_TIMEOUT-th consecutive wait cycle, mem_err sets and stays set until rst. The counter clears whenever mw=0.
- ex_rd==0 never causes a stall.
- A simultaneous lu_hit and ex_redirect: the redirect wins and no stall is taken.

Decomposition:
- Shared package hazard_pkg holds:
  - the state encoding (RUN=2'd0, LU_STALL=2'd1, MEM_WAIT=2'd2);
  - the NOP control constant;
  - the register-x0 constant 5'd0.
- One natural sub-module, hazard_perf_cnt, holds the two wrap-around counters and the watchdog. The FSM and output decode stay in the top level.

Test Plan:
- Load x5 in EX, ID reads x5 via rs2 with id_use_rs2=1 (LOAD_USE_STALL=1) -> 1 cycle with pc_we=0, ifid_we=0, idex_bubble=1; next cycle all enables 1; stall_cycles=1.
- Load to x0 in EX, ID rs1=0 -> no stall; pc_we stays 1.
- mem_req=1, mem_ready=0 for 4 cycles, then 1 -> 4 cycles with all enables 0 and memwb_bubble=1; resumes RUN; stall_cycles=4; mem_err=0.
- ex_redirect=1 together with lu_hit=1 -> ifid_flush=1, idex_bubble=1, pc_we=1, no stall cycle; flush_count=1.
- LOAD_USE_STALL=2, mw asserted during LU_STALL for 3 cycles -> stall count frozen; after mem_ready, 1 more LU_STALL cycle, then RUN.
- MEM_TIMEOUT=8, mem_ready held 0 -> mem_err rises on the 8th wait cycle and stays 1 after ready; rst pulse mid-wait -> state RUN, counters 0, mem_err 0.
